hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Decode-stage sequencer for the 5-stage MIPS pipeline. Detects load-use hazards and
//  taken branches, and drives PC / IF-ID write enables, the IF-ID flush and the ID-EX bubble.
//  Also drives a registered ext_mode for the immediate extender, aligned with its posedge output.
//  Provides a halt/drain/resume sequence for the debug unit.
// PARAMETERS
//  PIPE_DRAIN   3   cycles of bubbles issued after halt_req before HALT (range 1..7)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  id_instr       in   32  instruction held in IF-ID register
//  idex_memread   in   1   instruction in EX is a load
//  idex_rt        in   5   destination rt of instruction in EX
//  branch_taken   in   1   branch/jump resolved taken in ID this cycle
//  halt_req       in   1   debug halt request, level
//  resume         in   1   debug resume pulse, honoured only in HALT
//  pc_write       out  1   PC update enable
//  ifid_write     out  1   IF-ID register load enable
//  ifid_flush     out  1   IF-ID loads NOP
//  idex_bubble    out  1   ID-EX loads NOP (all control zero)
//  ext_mode       out  2   00 sign, 01 zero, 10 lui (imm<<16); registered
//  halted         out  1   1 while state == HALT
// BEHAVIOUR
//  FSM state[1:0]: RUN=00, DRAIN=01, HALT=10 (11 unreachable, decodes as RUN next cycle).
//  Reset: state=RUN, drain_cnt=0, ext_mode=00, halted=0.
//  rs=id_instr[25:21], rt=id_instr[20:16], op=id_instr[31:26].
//  uses_rt = op in {00,04,05,28,29,2B} (R-type, beq, bne, sb, sh, sw).
//  load_use = idex_memread & (idex_rt!=0) & (idex_rt==rs | (uses_rt & idex_rt==rt)).
//  Outputs combinational from state + inputs (same-cycle hazard response).
//  RUN, priority branch_taken > load_use > halt_req > normal:
//   - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0; stay RUN.
//   - load_use: pc_write=0, ifid_write=0, idex_bubble=1; exactly one bubble per hazard
//     (hazard clears itself when load leaves EX); stay RUN.
//   - halt_req: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1; drain_cnt<=PIPE_DRAIN-1;
//     ->DRAIN (or ->HALT directly if PIPE_DRAIN==1).
//   - else: pc_write=1, ifid_write=1, flush=0, bubble=0.
//  DRAIN: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1; drain_cnt decrements;
//   ->HALT when drain_cnt==1 at posedge. halt_req deassert mid-DRAIN ignored (drain completes).
//  HALT: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. resume=1 -> RUN next cycle;
//   resume outside HALT ignored. halt_req still high on resume: one RUN cycle, then halt again.
//  ext_mode, registered at posedge: loads decode of op when ifid_write... specifically when the
//   ID-EX stage advances (idex_bubble=0); 01 for op 0C/0D/0E, 10 for op 0F, else 00;
//   loads 00 when idex_bubble=1.
//  branch_taken and load_use same cycle: branch wins; the flushed slot kills the hazard.
//  Reset mid-DRAIN/HALT: back to RUN next cycle, counters cleared.
// CONFIGURATION
//  HAZARD_STATS_EN defined: adds outputs stall_count[15:0], flush_count[15:0]; stall_count +1
//   per load_use bubble cycle, flush_count +1 per branch flush; both saturate at 16'hFFFF;
//   cleared by reset; frozen in DRAIN/HALT.
//  Not defined: ports and counters absent; no other behaviour change.
// TESTING
//  lw $2 in EX (memread=1, rt=2), ID=add $3,$2,$4 -> one cycle pc_write=0, idex_bubble=1, then run.
//  Same with idex_rt=0 -> no stall; with ID=addi $2,$5,1 and rt match only -> no stall.
//  branch_taken=1 with load_use=1 -> ifid_flush=1, pc_write=1, idex_bubble=0.
//  ID=ori (op 0D) -> ext_mode=01 next edge; lui (0F) -> 10; lw (23) -> 00; held 00 on bubble.
//  halt_req pulse, PIPE_DRAIN=3 -> 3 bubble cycles, halted=1 on 4th; resume -> RUN, pc_write=1.
//  HAZARD_STATS_EN: 5 load-use stalls + 2 flushes -> stall_count=5, flush_count=2; reset -> 0.

Source files
------------

// File: rtl/hazard_if.sv
// Decode-stage hazard bundle between the pipeline datapath (master) and the
// hazard/debug sequencer (slave).
interface hazard_if;
  logic [31:0] id_instr;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic        branch_taken;
  logic        halt_req;
  logic        resume;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [1:0]  ext_mode;
  logic        halted;

  modport master (
    output id_instr, idex_memread, idex_rt, branch_taken, halt_req, resume,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ext_mode, halted
  );

  modport slave (
    input  id_instr, idex_memread, idex_rt, branch_taken, halt_req, resume,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ext_mode, halted
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencer: load-use stall, branch flush, immediate-extend mode and
// debug halt/drain/resume. Optional HAZARD_STATS_EN adds stall/flush event counters.
module hazard_ctrl #(
  parameter int PIPE_DRAIN = 3
) (
  input  logic        clk,
  input  logic        reset,
  hazard_if.slave     bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(PIPE_DRAIN - 1);

  function automatic logic [1:0] ext_decode(input logic [5:0] opc);
    case (opc)
      6'h0C, 6'h0D, 6'h0E: return 2'b01;
      6'h0F:               return 2'b10;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       load_use;
  logic       unused_imm;

  assign op         = bus.id_instr[31:26];
  assign rs         = bus.id_instr[25:21];
  assign rt         = bus.id_instr[20:16];
  assign unused_imm = ^bus.id_instr[15:0];

  always_comb begin
    uses_rt = 1'b0;
    case (op)
      6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B: uses_rt = 1'b1;
      default:                                  uses_rt = 1'b0;
    endcase
  end

  // rt only counts as a source for formats that actually read it
  assign load_use = bus.idex_memread & (bus.idex_rt != 5'd0) &
                    ((bus.idex_rt == rs) | (uses_rt & (bus.idex_rt == rt)));

  state_t     state_q;
  state_t     state_d;
  logic [2:0] cnt_q;
  logic [2:0] cnt_d;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       halted;
  logic [1:0] ext_mode_p1;

  always_comb begin
    state_d     = RUN;
    cnt_d       = cnt_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    halted      = 1'b0;
    case (state_q)
      RUN: begin
        state_d = RUN;
        if (bus.branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b0;
        end else if (load_use) begin
          idex_bubble = 1'b1;
        end else if (bus.halt_req) begin
          ifid_flush = 1'b1;
          cnt_d      = DRAIN_INIT;
          state_d    = (PIPE_DRAIN == 1) ? HALT : DRAIN;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b0;
        end
      end
      DRAIN: begin
        // drain runs to completion even if halt_req drops
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q <= 3'd1) ? HALT : DRAIN;
      end
      HALT: begin
        halted  = 1'b1;
        state_d = bus.resume ? RUN : HALT;
      end
      default: state_d = RUN;
    endcase
  end

  // ID -> EX boundary: extender mode travels with the instruction entering EX
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      ext_mode_p1 <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ext_mode_p1 <= idex_bubble ? 2'b00 : ext_decode(op);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else if (state_q == RUN) begin
      if (bus.branch_taken) begin
        flush_count <= sat_inc(flush_count);
      end else if (load_use) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end
`else
  logic [15:0] unused_sat;
  assign unused_sat = sat_inc(16'd0);
`endif

  assign bus.pc_write    = pc_write;
  assign bus.ifid_write  = ifid_write;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.ext_mode    = ext_mode_p1;
  assign bus.halted      = halted;

endmodule
